// File: rtl/sample_stream_ctrl.sv
// Sample playback controller: fetches 32-bit words from memory and plays them
// out as two 16-bit samples per word, one per sample_tick, in either direction.
module sample_stream_ctrl #(
    parameter int unsigned          ADDR_W     = 23,
    parameter logic [ADDR_W-1:0]    START_ADDR = '0,
    parameter logic [ADDR_W-1:0]    END_ADDR   = 23'h7FFFF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sample_tick,
    input  logic              play,
    input  logic              forward,
    input  logic              restart,
    output logic              mem_read,
    output logic [ADDR_W-1:0] mem_address,
    input  logic              mem_waitrequest,
    input  logic [31:0]       mem_readdata,
    input  logic              mem_readdatavalid,
    output logic [15:0]       audio_out,
    output logic              audio_valid,
    output logic              underrun
);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] FETCH     = 3'd1;
    localparam logic [2:0] WAIT_DATA = 3'd2;
    localparam logic [2:0] FIRST     = 3'd3;
    localparam logic [2:0] SECOND    = 3'd4;

    logic [2:0]        state, state_n;
    logic [31:0]       buffer, buffer_n;
    logic              swap, swap_n;
    logic              drain, drain_n;
    logic [ADDR_W-1:0] addr_n, addr_inc, addr_dec;
    logic [15:0]       audio_n;
    logic              valid_n, underrun_n, consume;

    always_comb begin
        addr_inc = (mem_address == END_ADDR)   ? START_ADDR : mem_address + ADDR_W'(1);
        addr_dec = (mem_address == START_ADDR) ? END_ADDR   : mem_address - ADDR_W'(1);
    end

    always_comb begin
        state_n    = state;
        buffer_n   = buffer;
        swap_n     = swap;
        drain_n    = drain;
        addr_n     = mem_address;
        audio_n    = audio_out;
        valid_n    = 1'b0;
        underrun_n = 1'b0;
        consume    = sample_tick && play;

        if (restart) begin
            buffer_n = '0;
            addr_n   = forward ? START_ADDR : END_ADDR;
            // A read already accepted by the slave must have its data swallowed
            // before a new request goes out, so park in WAIT_DATA until it lands.
            if ((state == WAIT_DATA && !mem_readdatavalid) ||
                (state == FETCH && !mem_waitrequest)) begin
                state_n = WAIT_DATA;
                drain_n = 1'b1;
            end else begin
                state_n = FETCH;
                drain_n = 1'b0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (play) state_n = FETCH;
                end
                FETCH: begin
                    underrun_n = consume;
                    if (!mem_waitrequest) state_n = WAIT_DATA;
                end
                WAIT_DATA: begin
                    underrun_n = consume;
                    if (mem_readdatavalid) begin
                        if (drain) begin
                            drain_n = 1'b0;
                            state_n = FETCH;
                        end else begin
                            buffer_n = mem_readdata;
                            swap_n   = !forward;
                            state_n  = FIRST;
                        end
                    end
                end
                FIRST: begin
                    if (consume) begin
                        audio_n = swap ? buffer[31:16] : buffer[15:0];
                        valid_n = 1'b1;
                        state_n = SECOND;
                    end
                end
                SECOND: begin
                    if (consume) begin
                        audio_n = swap ? buffer[15:0] : buffer[31:16];
                        valid_n = 1'b1;
                        addr_n  = forward ? addr_inc : addr_dec;
                        state_n = FETCH;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            mem_read    <= 1'b0;
            mem_address <= START_ADDR;
            audio_out   <= '0;
            audio_valid <= 1'b0;
            underrun    <= 1'b0;
            buffer      <= '0;
            swap        <= 1'b0;
            drain       <= 1'b0;
        end else begin
            state       <= state_n;
            mem_read    <= (state_n == FETCH);
            mem_address <= addr_n;
            audio_out   <= audio_n;
            audio_valid <= valid_n;
            underrun    <= underrun_n;
            buffer      <= buffer_n;
            swap        <= swap_n;
            drain       <= drain_n;
        end
    end

endmodule

// File: tb/tb_sample_stream_ctrl.sv
// Self-checking bench for sample_stream_ctrl: a queue-based playback model
// compared every cycle, plus directed scenarios with literal expectations.
module tb_sample_stream_ctrl;

    localparam int unsigned    AW = 23;
    localparam logic [AW-1:0]  S  = '0;
    localparam logic [AW-1:0]  E  = 23'h7FFFF;

    logic          clk = 1'b0;
    logic          reset, sample_tick, play, forward, restart;
    logic          mem_read, mem_waitrequest, mem_readdatavalid;
    logic [AW-1:0] mem_address;
    logic [31:0]   mem_readdata;
    logic [15:0]   audio_out;
    logic          audio_valid, underrun;

    always #5 clk = ~clk;

    sample_stream_ctrl #(
        .ADDR_W(AW),
        .START_ADDR(S),
        .END_ADDR(E)
    ) dut (
        .clk(clk),
        .reset(reset),
        .sample_tick(sample_tick),
        .play(play),
        .forward(forward),
        .restart(restart),
        .mem_read(mem_read),
        .mem_address(mem_address),
        .mem_waitrequest(mem_waitrequest),
        .mem_readdata(mem_readdata),
        .mem_readdatavalid(mem_readdatavalid),
        .audio_out(audio_out),
        .audio_valid(audio_valid),
        .underrun(underrun)
    );

    int passed = 0;
    int total  = 0;

    // Playback model: pending samples are a queue, the memory side is a few flags
    logic        m_active = 1'b0, m_req = 1'b0, m_pend = 1'b0, m_disc = 1'b0;
    logic [15:0] m_q[$];
    longint      m_addr = 0;
    logic [15:0] m_audio = '0;
    logic        m_valid = 1'b0, m_under = 1'b0;

    // Memory slave state
    logic [31:0]   mem[int];
    int            wait_cnt = 0, lat_extra = 0, resp_cnt = 0, read_cyc = 0;
    logic [31:0]   resp_data = '0;
    logic          stray = 1'b0;
    logic [AW-1:0] fetch_q[$];
    logic [15:0]   audio_log[$];
    int            valid_cnt = 0, under_cnt = 0;

    function automatic logic [31:0] word_of(input logic [AW-1:0] a);
        if (mem.exists(int'(a))) return mem[int'(a)];
        return 32'hF00D_0000 | {16'h0, a[15:0]};
    endfunction

    function automatic logic [AW-1:0] last_fetch();
        if (fetch_q.size() == 0) return '1;
        return fetch_q[fetch_q.size()-1];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic model_step(input logic r, input logic t, input logic p, input logic f,
                              input logic rs, input logic w, input logic v,
                              input logic [31:0] d);
        longint span;
        logic   busy;
        span = longint'(E) - longint'(S) + 1;
        m_valid = 1'b0;
        m_under = 1'b0;
        if (!r) begin
            m_active = 1'b0; m_req = 1'b0; m_pend = 1'b0; m_disc = 1'b0;
            m_q.delete();
            m_addr  = longint'(S);
            m_audio = '0;
            return;
        end
        if (rs) begin
            busy = (m_pend && !v) || (m_req && !w);
            m_q.delete();
            m_addr   = f ? longint'(S) : longint'(E);
            m_active = 1'b1;
            m_req    = !busy;
            m_pend   = busy;
            m_disc   = busy;
        end else if (!m_active) begin
            if (p) begin m_active = 1'b1; m_req = 1'b1; end
        end else if (m_req) begin
            m_under = t && p;
            if (!w) begin m_req = 1'b0; m_pend = 1'b1; end
        end else if (m_pend) begin
            m_under = t && p;
            if (v) begin
                m_pend = 1'b0;
                if (m_disc) begin m_disc = 1'b0; m_req = 1'b1; end
                else if (f) m_q = '{d[15:0], d[31:16]};
                else        m_q = '{d[31:16], d[15:0]};
            end
        end else if (t && p && m_q.size() > 0) begin
            m_audio = m_q.pop_front();
            m_valid = 1'b1;
            if (m_q.size() == 0) begin
                if (f) m_addr = longint'(S) + (m_addr - longint'(S) + 1) % span;
                else   m_addr = longint'(S) + (m_addr - longint'(S) + span - 1) % span;
                m_req = 1'b1;
            end
        end
    endtask

    // One clock: model update + compare after posedge, slave response at negedge
    task automatic step();
        logic cr, ct, cp, cf, crs, cw, cv;
        logic [31:0] cd;
        @(posedge clk);
        cr = reset; ct = sample_tick; cp = play; cf = forward; crs = restart;
        cw = mem_waitrequest; cv = mem_readdatavalid; cd = mem_readdata;
        model_step(cr, ct, cp, cf, crs, cw, cv, cd);
        #1;
        check("mem_read",    32'(mem_read),    32'(m_req));
        check("mem_address", 32'(mem_address), 32'(m_addr[AW-1:0]));
        check("audio_out",   32'(audio_out),   32'(m_audio));
        check("audio_valid", 32'(audio_valid), 32'(m_valid));
        check("underrun",    32'(underrun),    32'(m_under));
        if (audio_valid) begin audio_log.push_back(audio_out); valid_cnt++; end
        if (underrun) under_cnt++;
        @(negedge clk);
        mem_readdatavalid = 1'b0;
        if (stray) begin
            mem_readdatavalid = 1'b1;
            mem_readdata      = 32'hDEAD_BEEF;
            stray             = 1'b0;
        end else if (resp_cnt > 0) begin
            resp_cnt--;
            if (resp_cnt == 0) begin
                mem_readdatavalid = 1'b1;
                mem_readdata      = resp_data;
            end
        end
        mem_waitrequest = 1'b0;
        if (mem_read) begin
            read_cyc++;
            if (wait_cnt > 0) begin
                mem_waitrequest = 1'b1;
                wait_cnt--;
            end else begin
                fetch_q.push_back(mem_address);
                resp_data = word_of(mem_address);
                resp_cnt  = 1 + lat_extra;
            end
        end
    endtask

    task automatic tick();
        sample_tick = 1'b1;
        step();
        sample_tick = 1'b0;
    endtask

    task automatic wait_ready(input string name, input int budget);
        int n = 0;
        while (!(m_q.size() == 2 && !m_req && !m_pend) && n < budget) begin
            step();
            n++;
        end
        check({name, "_ready"}, 32'(n < budget), 32'h1);
    endtask

    initial begin
        int base, v0, u0, rc0, sz;
        logic [15:0] a0;
        reset = 1'b0; play = 1'b0; forward = 1'b1; sample_tick = 1'b0; restart = 1'b0;
        mem_waitrequest = 1'b0; mem_readdatavalid = 1'b0; mem_readdata = '0;
        repeat (3) step();
        reset = 1'b1;
        check("rst_mem_read",    32'(mem_read),    32'h0);
        check("rst_mem_address", 32'(mem_address), 32'h0);
        check("rst_audio_out",   32'(audio_out),   32'h0);
        check("rst_audio_valid", 32'(audio_valid), 32'h0);
        check("rst_underrun",    32'(underrun),    32'h0);

        // Forward playback of word 0, then fetch of word 1
        mem[0] = 32'hBBBB_AAAA; play = 1'b1; forward = 1'b1;
        base = audio_log.size();
        wait_ready("s1a", 20);
        check("s1_first_addr", 32'(fetch_q[0]), 32'h0);
        tick();
        check("s1_valid1", 32'(audio_valid), 32'h1);
        check("s1_audio1", 32'(audio_out), 32'hAAAA);
        tick();
        check("s1_audio2", 32'(audio_out), 32'hBBBB);
        wait_ready("s1b", 20);
        check("s1_valid_count", 32'(audio_log.size() - base), 32'd2);
        check("s1_next_addr", 32'(last_fetch()), 32'h1);
        check("s1_mem_address", 32'(mem_address), 32'h1);

        // Backward from START: swapped halves, then wrap to END
        mem[0] = 32'h2222_1111; forward = 1'b1; restart = 1'b1;
        step();
        restart = 1'b0; forward = 1'b0;
        wait_ready("s2a", 20);
        check("s2_addr", 32'(last_fetch()), 32'h0);
        tick();
        check("s2_audio1", 32'(audio_out), 32'h2222);
        tick();
        check("s2_audio2", 32'(audio_out), 32'h1111);
        wait_ready("s2b", 20);
        check("s2_wrap_down", 32'(last_fetch()), 32'h7FFFF);

        // Direction flip keeps buffered half order; forward from END wraps to START
        forward = 1'b1;
        tick();
        check("s3_audio1", 32'(audio_out), 32'hF00D);
        tick();
        check("s3_audio2", 32'(audio_out), 32'hFFFF);
        wait_ready("s3", 20);
        check("s3_wrap_up", 32'(last_fetch()), 32'h0);
        check("s3_mem_address", 32'(mem_address), 32'h0);

        // Stalled fetch with a tick arriving during FETCH
        tick();
        check("s4_audio1", 32'(audio_out), 32'h1111);
        wait_cnt = 3; rc0 = read_cyc;
        tick();
        check("s4_audio2", 32'(audio_out), 32'h2222);
        v0 = valid_cnt; u0 = under_cnt;
        tick();
        check("s4_underrun_pulse", 32'(underrun), 32'h1);
        wait_ready("s4", 20);
        check("s4_underruns", 32'(under_cnt - u0), 32'd1);
        check("s4_no_valid", 32'(valid_cnt - v0), 32'd0);
        check("s4_audio_hold", 32'(audio_out), 32'h2222);
        check("s4_read_cycles", 32'(read_cyc - rc0), 32'd4);
        check("s4_addr", 32'(last_fetch()), 32'h1);

        // Restart coinciding with a tick in SECOND
        tick();
        check("s5_audio1", 32'(audio_out), 32'h0001);
        v0 = valid_cnt; u0 = under_cnt;
        restart = 1'b1; sample_tick = 1'b1; forward = 1'b1;
        step();
        restart = 1'b0; sample_tick = 1'b0;
        check("s5_no_valid_now", 32'(audio_valid), 32'h0);
        check("s5_no_under_now", 32'(underrun), 32'h0);
        wait_ready("s5", 20);
        check("s5_no_valid", 32'(valid_cnt - v0), 32'd0);
        check("s5_no_under", 32'(under_cnt - u0), 32'd0);
        check("s5_addr", 32'(last_fetch()), 32'h0);

        // Paused: ticks ignored, then resume plays the first half
        play = 1'b0; v0 = valid_cnt; u0 = under_cnt; a0 = audio_out;
        for (int i = 0; i < 5; i++) begin
            tick();
            step();
        end
        check("s6_audio_hold", 32'(audio_out), 32'(a0));
        check("s6_no_valid", 32'(valid_cnt - v0), 32'd0);
        check("s6_no_under", 32'(under_cnt - u0), 32'd0);
        play = 1'b1;
        tick();
        check("s6_audio", 32'(audio_out), 32'h1111);
        check("s6_valid", 32'(audio_valid), 32'h1);

        // Restart while a slow read is outstanding: stale data is discarded
        lat_extra = 3;
        tick();
        check("s7_audio0", 32'(audio_out), 32'h2222);
        step(); step();
        mem[0] = 32'h4444_3333; u0 = under_cnt;
        restart = 1'b1; forward = 1'b1;
        step();
        restart = 1'b0;
        tick();
        wait_ready("s7", 40);
        sz = fetch_q.size();
        check("s7_stale_addr", 32'(fetch_q[sz-2]), 32'h1);
        check("s7_addr", 32'(last_fetch()), 32'h0);
        check("s7_underruns", 32'(under_cnt - u0), 32'd1);
        tick();
        check("s7_audio1", 32'(audio_out), 32'h3333);
        stray = 1'b1;
        step(); step();
        check("s7_stray_hold", 32'(audio_out), 32'h3333);
        tick();
        check("s7_audio2", 32'(audio_out), 32'h4444);

        // Reset mid-read: late readdatavalid is ignored in IDLE
        step(); step();
        reset = 1'b0; play = 1'b0;
        step();
        reset = 1'b1;
        check("s8_mem_read", 32'(mem_read), 32'h0);
        check("s8_mem_address", 32'(mem_address), 32'h0);
        check("s8_audio_out", 32'(audio_out), 32'h0);
        repeat (5) step();
        check("s8_idle_read", 32'(mem_read), 32'h0);
        check("s8_idle_audio", 32'(audio_out), 32'h0);
        lat_extra = 0; play = 1'b1;
        wait_ready("s8", 20);
        check("s8_addr", 32'(last_fetch()), 32'h0);
        tick();
        check("s8_audio", 32'(audio_out), 32'h3333);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
